// File: rtl/student_tlul_arb_pkg.sv
// Sizing helpers for the TL-UL host arbiter and its response-routing ID FIFO.
// Pure constants and functions; no logic.
package student_tlul_arb_pkg;

  localparam int DefaultOutstanding = 4;

  // Host index width; a single host still needs one bit of storage.
  function automatic int id_width(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

  // Occupancy counter spans 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/tlul_pkg.sv
// Minimal TL-UL channel structs shared by hosts, devices and interconnect.
// A-channel request fields plus d_ready travel host->device; D-channel response plus a_ready travel back.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

// File: rtl/student_tlul_arbiter_if.sv
// Signal bundle around the N-to-1 TL-UL arbiter: host and device channels plus status.
// master = host/device environment side, slave = arbiter side.
interface student_tlul_arbiter_if #(
  parameter int NUM         = 2,
  parameter int OUTSTANDING = 4
);
  tlul_pkg::tl_h2d_t [NUM-1:0]    host_req;
  tlul_pkg::tl_d2h_t [NUM-1:0]    host_rsp;
  tlul_pkg::tl_h2d_t              dev_req;
  tlul_pkg::tl_d2h_t              dev_rsp;
  logic                           busy;
  logic [$clog2(OUTSTANDING):0]   outstanding;

  modport master (
    output host_req, dev_rsp,
    input  host_rsp, dev_req, busy, outstanding
  );

  modport slave (
    input  host_req, dev_rsp,
    output host_rsp, dev_req, busy, outstanding
  );
endinterface

// File: rtl/student_tlul_arb_idfifo.sv
// In-order FIFO of granted host indices; push/pop take effect at the clock edge, dout is the head.
// Pushes while full and pops while empty are ignored; simultaneous push+pop keeps occupancy.
module student_tlul_arb_idfifo
  import student_tlul_arb_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = DefaultOutstanding
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic [WIDTH-1:0]              din_i,
  output logic [WIDTH-1:0]              dout_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [occ_width(DEPTH)-1:0]   count_o
);
  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = occ_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PtrW'(1);
    if (do_pop)  rd_d = rd_q + PtrW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/student_tlul_arbiter.sv
// N-to-1 TL-UL host arbiter: zero-latency round-robin A grant held until handshake, D routed in order.
// Full ID FIFO blocks A; STUDENT_TLUL_ARB_FIXED_PRIO_EN selects lowest-index-wins instead of round-robin.
module student_tlul_arbiter
  import student_tlul_arb_pkg::*;
#(
  parameter int NUM         = 2,
  parameter int OUTSTANDING = DefaultOutstanding
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  tlul_pkg::tl_h2d_t [NUM-1:0]   tl_host_i,
  output tlul_pkg::tl_d2h_t [NUM-1:0]   tl_host_o,
  output tlul_pkg::tl_h2d_t             tl_device_o,
  input  tlul_pkg::tl_d2h_t             tl_device_i,
  output logic                          busy_o,
  output logic [$clog2(OUTSTANDING):0]  outstanding_o
);
  localparam int IdW  = id_width(NUM);
  localparam int OccW = occ_width(OUTSTANDING);

  logic [IdW-1:0]  rr_q, rr_d, gnt_q, gnt_d, grant, head;
  logic            lock_q, lock_d, gnt_vld;
  logic            fifo_full, fifo_empty, push, pop;
  logic            dev_a_vld, host_a_rdy, dev_d_rdy;
  logic [OccW-1:0] occ;
`ifndef STUDENT_TLUL_ARB_FIXED_PRIO_EN
  int              scan_idx;
`endif

  // Scan runs from the far end back so the last hit is the first host in priority order.
  always_comb begin
    grant   = gnt_q;
    gnt_vld = 1'b0;
`ifndef STUDENT_TLUL_ARB_FIXED_PRIO_EN
    scan_idx = 0;
`endif
    if (lock_q) begin
      gnt_vld = 1'b1;
    end else begin
`ifdef STUDENT_TLUL_ARB_FIXED_PRIO_EN
      for (int i = NUM - 1; i >= 0; i--) begin
        if (tl_host_i[i].a_valid) begin
          grant   = IdW'(i);
          gnt_vld = 1'b1;
        end
      end
`else
      for (int k = NUM - 1; k >= 0; k--) begin
        scan_idx = int'(rr_q) + k;
        if (scan_idx >= NUM) scan_idx = scan_idx - NUM;
        if (tl_host_i[scan_idx].a_valid) begin
          grant   = IdW'(scan_idx);
          gnt_vld = 1'b1;
        end
      end
`endif
    end
  end

  assign dev_a_vld  = !rst_i && gnt_vld && tl_host_i[grant].a_valid && !fifo_full;
  assign host_a_rdy = !rst_i && gnt_vld && tl_device_i.a_ready && !fifo_full;
  assign push       = dev_a_vld && tl_device_i.a_ready;
  // With nothing outstanding, stray responses are accepted and dropped.
  assign dev_d_rdy  = fifo_empty ? 1'b1 : tl_host_i[head].d_ready;
  assign pop        = !fifo_empty && tl_device_i.d_valid && dev_d_rdy;

  always_comb begin
    tl_device_o         = tl_host_i[grant];
    tl_device_o.a_valid = dev_a_vld;
    tl_device_o.d_ready = dev_d_rdy;
  end

  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      tl_host_o[i]         = tl_device_i;
      tl_host_o[i].a_ready = host_a_rdy && (grant == IdW'(i));
      tl_host_o[i].d_valid = !rst_i && !fifo_empty && (head == IdW'(i)) && tl_device_i.d_valid;
    end
  end

  // A stalled request pins the grant so the device sees a stable payload.
  always_comb begin
    rr_d   = rr_q;
    gnt_d  = gnt_q;
    lock_d = lock_q;
    if (push) begin
      lock_d = 1'b0;
`ifndef STUDENT_TLUL_ARB_FIXED_PRIO_EN
      rr_d = (grant == IdW'(NUM - 1)) ? '0 : grant + IdW'(1);
`endif
    end else if (dev_a_vld) begin
      lock_d = 1'b1;
      gnt_d  = grant;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q   <= '0;
      gnt_q  <= '0;
      lock_q <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      gnt_q  <= gnt_d;
      lock_q <= lock_d;
    end
  end

  student_tlul_arb_idfifo #(
    .WIDTH (IdW),
    .DEPTH (OUTSTANDING)
  ) u_idfifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (grant),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occ)
  );

  assign busy_o        = !fifo_empty;
  assign outstanding_o = occ;

endmodule

// File: tb/tb_student_tlul_arbiter.sv
// Bench for student_tlul_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a queue-based model of the arbitration and routing rules.
module tb_student_tlul_arbiter;
  import tlul_pkg::*;

  localparam int NUM   = 3;
  localparam int OUTST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  student_tlul_arbiter_if #(.NUM(NUM), .OUTSTANDING(OUTST)) bus ();

  student_tlul_arbiter #(.NUM(NUM), .OUTSTANDING(OUTST)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .tl_host_i     (bus.host_req),
    .tl_host_o     (bus.host_rsp),
    .tl_device_o   (bus.dev_req),
    .tl_device_i   (bus.dev_rsp),
    .busy_o        (bus.busy),
    .outstanding_o (bus.outstanding)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: queue of granted host indices, next scan start, locked host (-1 = none).
  int mq[$];
  int m_rr   = 0;
  int m_lock = -1;
  bit hs [NUM];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic host_set(input int i, input bit vld, input logic [31:0] addr,
                          input logic [31:0] data, input logic [7:0] src);
    bus.host_req[i].a_valid   = vld;
    bus.host_req[i].a_opcode  = 3'h0;
    bus.host_req[i].a_param   = 3'h0;
    bus.host_req[i].a_size    = 2'd2;
    bus.host_req[i].a_source  = src;
    bus.host_req[i].a_address = addr;
    bus.host_req[i].a_mask    = 4'hF;
    bus.host_req[i].a_data    = data;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_step();
    int  g, start, head;
    bit  full, empty, exp_av, exp_dr, exp_dv, exp_ar, push, pop;
    full  = (mq.size() == OUTST);
    empty = (mq.size() == 0);
    head  = empty ? -1 : mq[0];
`ifdef STUDENT_TLUL_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_rr;
`endif
    g = -1;
    if (m_lock >= 0) g = m_lock;
    else
      for (int k = 0; k < NUM; k++)
        if (g < 0 && bus.host_req[(start + k) % NUM].a_valid) g = (start + k) % NUM;

    exp_av = !rst && (g >= 0) && !full && bus.host_req[(g < 0) ? 0 : g].a_valid;
    chk("dev_a_valid", 64'(bus.dev_req.a_valid), 64'(exp_av));
    if (exp_av) begin
      chk("dev_a_address", 64'(bus.dev_req.a_address), 64'(bus.host_req[g].a_address));
      chk("dev_a_data",    64'(bus.dev_req.a_data),    64'(bus.host_req[g].a_data));
      chk("dev_a_source",  64'(bus.dev_req.a_source),  64'(bus.host_req[g].a_source));
      chk("dev_a_size",    64'(bus.dev_req.a_size),    64'(bus.host_req[g].a_size));
    end
    for (int i = 0; i < NUM; i++) begin
      exp_ar = !rst && (i == g) && bus.dev_rsp.a_ready && !full;
      chk($sformatf("host%0d_a_ready", i), 64'(bus.host_rsp[i].a_ready), 64'(exp_ar));
    end
    exp_dr = empty ? 1'b1 : bus.host_req[head].d_ready;
    chk("dev_d_ready", 64'(bus.dev_req.d_ready), 64'(exp_dr));
    for (int i = 0; i < NUM; i++) begin
      exp_dv = !rst && !empty && (head == i) && bus.dev_rsp.d_valid;
      chk($sformatf("host%0d_d_valid", i), 64'(bus.host_rsp[i].d_valid), 64'(exp_dv));
      if (exp_dv) begin
        chk($sformatf("host%0d_d_data", i),   64'(bus.host_rsp[i].d_data),   64'(bus.dev_rsp.d_data));
        chk($sformatf("host%0d_d_source", i), 64'(bus.host_rsp[i].d_source), 64'(bus.dev_rsp.d_source));
      end
    end
    chk("busy", 64'(bus.busy), 64'(!empty));
    chk("outstanding", 64'(bus.outstanding), 64'(mq.size()));

    if (rst) begin
      mq.delete();
      m_rr   = 0;
      m_lock = -1;
    end else begin
      push = exp_av && bus.dev_rsp.a_ready;
      pop  = !empty && bus.dev_rsp.d_valid && exp_dr;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(g);
        m_lock = -1;
`ifndef STUDENT_TLUL_ARB_FIXED_PRIO_EN
        m_rr = (g + 1) % NUM;
`endif
      end else if (exp_av) begin
        m_lock = g;
      end
    end
  endtask

  // Compare process: outputs are stable mid-cycle; model state advances as the DUT will at the next edge.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  initial begin
    int gnt;
    int exp_seq [4];
`ifdef STUDENT_TLUL_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 0, 1};
`endif
    bus.host_req = '0;
    bus.dev_rsp  = '0;
    for (int i = 0; i < NUM; i++) bus.host_req[i].d_ready = 1'b1;

    // Reset: requests and device readiness must not leak through.
    host_set(0, 1, 32'h100, 32'hDEADBEEF, 8'd3);
    bus.dev_rsp.a_ready = 1'b1;
    cyc(); #1;
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_outstanding", 64'(bus.outstanding), 64'(0));
    chk("rst_dev_a_valid", 64'(bus.dev_req.a_valid), 64'(0));
    chk("rst_host0_a_ready", 64'(bus.host_rsp[0].a_ready), 64'(0));

    // Single host write and response.
    cyc(); rst = 1'b0; #1;
    chk("p1_dev_a_valid", 64'(bus.dev_req.a_valid), 64'(1));
    chk("p1_dev_addr", 64'(bus.dev_req.a_address), 64'h100);
    chk("p1_dev_data", 64'(bus.dev_req.a_data), 64'hDEADBEEF);
    chk("p1_dev_source", 64'(bus.dev_req.a_source), 64'd3);
    chk("p1_host0_a_ready", 64'(bus.host_rsp[0].a_ready), 64'(1));
    chk("p1_host1_a_ready", 64'(bus.host_rsp[1].a_ready), 64'(0));
    cyc();
    host_set(0, 0, 32'h0, 32'h0, 8'd0);
    bus.dev_rsp.d_valid  = 1'b1;
    bus.dev_rsp.d_source = 8'd3;
    bus.dev_rsp.d_data   = 32'h1234_5678;
    #1;
    chk("p1_outstanding_1", 64'(bus.outstanding), 64'(1));
    chk("p1_host0_d_valid", 64'(bus.host_rsp[0].d_valid), 64'(1));
    chk("p1_host1_d_valid", 64'(bus.host_rsp[1].d_valid), 64'(0));
    chk("p1_host0_d_source", 64'(bus.host_rsp[0].d_source), 64'd3);
    cyc(); bus.dev_rsp.d_valid = 1'b0; #1;
    chk("p1_outstanding_0", 64'(bus.outstanding), 64'(0));
    chk("p1_busy_0", 64'(bus.busy), 64'(0));

    // Round-robin between two continuously valid hosts.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    host_set(0, 1, 32'h200, 32'hA0, 8'd1);
    host_set(1, 1, 32'h300, 32'hB0, 8'd2);
    bus.dev_rsp.a_ready = 1'b1;
    bus.dev_rsp.d_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      gnt = bus.host_rsp[0].a_ready ? 0 : bus.host_rsp[1].a_ready ? 1 : bus.host_rsp[2].a_ready ? 2 : 9;
      chk($sformatf("p2_grant%0d", k), 64'(gnt), 64'(exp_seq[k]));
      if (k == 0)
        chk("p2_stray_drop", 64'(bus.host_rsp[0].d_valid | bus.host_rsp[1].d_valid), 64'(0));
      else
        chk($sformatf("p2_resp%0d", k), 64'(bus.host_rsp[exp_seq[k-1]].d_valid), 64'(1));
      cyc();
      if (gnt < NUM) host_set(gnt, 1, 32'h1000 + 32'(k * 4), 32'(k), 8'(gnt + 1));
    end
    host_set(0, 0, 32'h0, 32'h0, 8'd0);
    host_set(1, 0, 32'h0, 32'h0, 8'd0);
    bus.dev_rsp.d_valid = 1'b0;

    // Backpressure lock on host1 while host0 becomes valid.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    host_set(1, 1, 32'h400, 32'hA5A5, 8'd5);
    bus.dev_rsp.a_ready = 1'b0;
    #1;
    chk("p3_c0_addr", 64'(bus.dev_req.a_address), 64'h400);
    for (int c = 1; c < 3; c++) begin
      cyc();
      host_set(0, 1, 32'h500, 32'h5A5A, 8'd6);
      #1;
      chk($sformatf("p3_c%0d_addr", c), 64'(bus.dev_req.a_address), 64'h400);
      chk($sformatf("p3_c%0d_src", c), 64'(bus.dev_req.a_source), 64'd5);
      chk($sformatf("p3_c%0d_h0_rdy", c), 64'(bus.host_rsp[0].a_ready), 64'(0));
    end
    cyc(); bus.dev_rsp.a_ready = 1'b1; #1;
    chk("p3_h1_rdy", 64'(bus.host_rsp[1].a_ready), 64'(1));
    chk("p3_h0_wait", 64'(bus.host_rsp[0].a_ready), 64'(0));
    cyc(); host_set(1, 0, 32'h0, 32'h0, 8'd0); #1;
    chk("p3_h0_rdy", 64'(bus.host_rsp[0].a_ready), 64'(1));
    chk("p3_h0_addr", 64'(bus.dev_req.a_address), 64'h500);
    cyc(); host_set(0, 0, 32'h0, 32'h0, 8'd0);

    // Full FIFO blocks A, even on a same-cycle pop.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    host_set(0, 1, 32'h600, 32'h0, 8'd7);
    for (int k = 0; k < OUTST; k++) begin
      #1;
      chk($sformatf("p4_accept%0d", k), 64'(bus.host_rsp[0].a_ready), 64'(1));
      cyc();
      host_set(0, 1, 32'h604 + 32'(k * 4), 32'(k), 8'd7);
    end
    #1;
    chk("p4_full_occ", 64'(bus.outstanding), 64'(OUTST));
    chk("p4_full_rdy", 64'(bus.host_rsp[0].a_ready), 64'(0));
    chk("p4_full_dev_vld", 64'(bus.dev_req.a_valid), 64'(0));
    cyc(); bus.dev_rsp.d_valid = 1'b1; #1;
    chk("p4_pop_rdy", 64'(bus.host_rsp[0].a_ready), 64'(0));
    chk("p4_pop_dvld", 64'(bus.host_rsp[0].d_valid), 64'(1));
    cyc(); bus.dev_rsp.d_valid = 1'b0; #1;
    chk("p4_after_pop_occ", 64'(bus.outstanding), 64'(OUTST - 1));
    chk("p4_after_pop_rdy", 64'(bus.host_rsp[0].a_ready), 64'(1));
    cyc(); #1;
    chk("p4_refill_occ", 64'(bus.outstanding), 64'(OUTST));
    host_set(0, 0, 32'h0, 32'h0, 8'd0);
    bus.dev_rsp.d_valid = 1'b1;
    cyc(); cyc(); bus.dev_rsp.d_valid = 1'b0; #1;
    chk("p5_two_left", 64'(bus.outstanding), 64'(2));

    // Reset with two outstanding: later responses are drained, not forwarded.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    bus.dev_rsp.d_valid  = 1'b1;
    bus.dev_rsp.d_source = 8'd9;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk($sformatf("p5_busy%0d", k), 64'(bus.busy), 64'(0));
      chk($sformatf("p5_drain%0d", k), 64'(bus.dev_req.d_ready), 64'(1));
      for (int i = 0; i < NUM; i++)
        chk($sformatf("p5_h%0d_dvld%0d", i, k), 64'(bus.host_rsp[i].d_valid), 64'(0));
      cyc();
    end
    bus.dev_rsp.d_valid = 1'b0;

    // Random traffic; hosts hold each request until its handshake.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      for (int i = 0; i < NUM; i++) hs[i] = bus.host_req[i].a_valid && bus.host_rsp[i].a_ready;
      cyc();
      rst = ($urandom_range(255) == 0);
      for (int i = 0; i < NUM; i++) begin
        if (!bus.host_req[i].a_valid || hs[i]) begin
          if ($urandom_range(3) != 0)
            host_set(i, 1, $urandom, $urandom, 8'($urandom_range(255)));
          else
            host_set(i, 0, 32'h0, 32'h0, 8'd0);
        end
        bus.host_req[i].d_ready = ($urandom_range(3) != 0);
      end
      bus.dev_rsp.a_ready  = ($urandom_range(3) != 0);
      bus.dev_rsp.d_valid  = ($urandom_range(1) != 0);
      bus.dev_rsp.d_data   = $urandom;
      bus.dev_rsp.d_source = 8'($urandom_range(255));
    end
    cyc(); rst = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
